cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 149 ++++++++++++++
 tb/tb_cacheline_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Bridges a full-line cache request onto a four-beat memory burst interface.
// Reads assemble beats into line_o; write-backs stream the captured line out beat by beat.
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~32'((LINE_W / 8) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [LINE_W-1:0]  wr_line_q, wr_line_d;
  logic [LINE_W-1:0]  rd_line_q, rd_line_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;
    read_d    = read_q;
    write_d   = write_q;
    resp_d    = 1'b0;
    burst_d   = burst_q;

    case (state_q)
      IDLE: begin
        // Write-back wins so a dirty victim reaches memory before its refill.
        if (write_i) begin
          state_d   = WR_BURST;
          addr_d    = address_i & ADDR_MASK;
          wr_line_d = line_i;
          cnt_d     = '0;
          write_d   = 1'b1;
          read_d    = 1'b0;
          burst_d   = line_i[BURST_W-1:0];
        end else if (read_i) begin
          state_d = RD_BURST;
          addr_d  = address_i & ADDR_MASK;
          cnt_d   = '0;
          read_d  = 1'b1;
          write_d = 1'b0;
        end
      end

      RD_BURST: begin
        if (resp_i) begin
          rd_line_d[cnt_q*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            read_d  = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end

      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            // Registered beat data is looked up with the advanced count.
            burst_d = wr_line_q[cnt_d*BURST_W +: BURST_W];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      resp_q    <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
      read_q    <= read_d;
      write_q   <= write_d;
      resp_q    <= resp_d;
      burst_q   <= burst_d;
    end
  end

  assign line_o    = rd_line_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = burst_q;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(read_q && write_q));

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: requests push expected completions and
// write beats; a negedge monitor pops and compares them as the DUT produces them.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  cacheline_adapter #(.LINE_W(256), .BURST_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  beat_q[$];
  logic [31:0]  cur_addr = '0;
  bit           exp_wr = 1'b0;
  logic [255:0] last_line = '0;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  exp_t         m_e;
  logic [63:0]  m_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: outputs and inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o || write_o) begin
        check("dir", {254'd0, read_o, write_o}, exp_wr ? 256'd1 : 256'd2);
        check("addr_hold", address_o, cur_addr);
      end
      if (write_o && resp_i) begin
        check("beat_pending", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          m_b = beat_q.pop_front();
          check("burst_o", burst_o, m_b);
        end
      end
      if (resp_o) begin
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("line_o", line_o, m_e.line);
          check("address_o", address_o, m_e.addr);
        end
      end
    end
  end

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [255:0] data, input logic [15:0] pat, input int plen);
    exp_t e;
    int   bi;
    int   t0;
    int   waited;
    @(posedge clk); #1;
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wr ? data : rand_line();
    cur_addr  = {addr[31:5], 5'b0};
    exp_wr    = wr;
    e.addr    = cur_addr;
    if (wr) begin
      e.line = last_line;
      for (int k = 0; k < 4; k++) beat_q.push_back(data[k*64 +: 64]);
    end else begin
      e.line    = data;
      last_line = data;
    end
    exp_q.push_back(e);
    t0 = cyc;
    bi = 0;
    for (int i = 0; i < plen; i++) begin
      @(posedge clk); #1;
      address_i = $urandom;
      line_i    = rand_line();
      resp_i    = pat[i];
      if (pat[i]) begin
        burst_i = data[bi*64 +: 64];
        bi++;
      end else begin
        burst_i = {$urandom, $urandom};
      end
    end
    waited = 0;
    do begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      waited++;
    end while (!resp_o && waited < 40);
    check("resp_seen", resp_o, 1);
    check("latency", cyc - t0, plen + 1);
    check("rd_wr_done", {read_o, write_o}, 0);
    read_i  = 1'b0;
    write_i = 1'b0;
    @(posedge clk); #1;
    check("resp_single", resp_o, 0);
    $display("[TB] %s addr=%h plen=%0d done", wr ? "write" : "read", addr, plen);
  endtask

  logic [255:0] d;
  logic [15:0]  pat;
  int           plen;

  initial begin
    rst = 1'b1; address_i = '0; read_i = 0; write_i = 0; line_i = '0;
    burst_i = '0; resp_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {read_o, write_o, resp_o}, 0);
    check("rst_line", line_o, 0);
    check("rst_burst", burst_o, 0);
    check("rst_addr", address_o, 0);
    rst = 1'b0;

    // Consecutive read fill
    d = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    do_req(0, 1, 32'h0000_1234, d, 16'h000F, 4);
    check("fill_addr", address_o, 32'h0000_1220);

    // Consecutive write-back
    do_req(1, 0, 32'h0000_8FFF, rand_line(), 16'h000F, 4);
    // Stalled beats 1,0,0,1,1,0,1
    do_req(0, 1, 32'hDEAD_BEEF, rand_line(), 16'h0059, 7);
    do_req(1, 0, 32'h1234_5678, rand_line(), 16'h0059, 7);
    // Both requests: write first
    do_req(1, 1, 32'h0000_4040, rand_line(), 16'h000F, 4);

    // Reset after two read beats
    d = rand_line();
    @(posedge clk); #1;
    read_i = 1'b1; address_i = 32'h0000_ABCD;
    cur_addr = 32'h0000_ABC0; exp_wr = 1'b0;
    @(posedge clk); #1; resp_i = 1'b1; burst_i = d[63:0];
    @(posedge clk); #1; burst_i = d[127:64];
    @(posedge clk); #1; resp_i = 1'b0;
    check("partial_line", line_o[127:0], d[127:0]);
    #2 rst = 1'b1; read_i = 1'b0;
    #1;
    check("arst_outs", {read_o, write_o, resp_o}, 0);
    check("arst_line", line_o, 0);
    check("arst_addr", address_o, 0);
    check("arst_burst", burst_o, 0);
    @(posedge clk); #1; rst = 1'b0; last_line = '0;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_resp_after_rst", resp_o, 0);
    end
    do_req(0, 1, 32'h0000_ABCD, rand_line(), 16'h000F, 4);

    // Spurious resp_i in IDLE
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      check("idle_line", line_o, last_line);
      check("idle_rdwr", {read_o, write_o, resp_o}, 0);
    end
    @(posedge clk); #1; resp_i = 1'b0;
    check("idle_line_end", line_o, last_line);
    do_req(0, 1, 32'h0F0F_0F0F, rand_line(), 16'h000F, 4);

    // Random mix with random stalls
    for (int n = 0; n < 6; n++) begin
      pat = '0; plen = 0;
      for (int k = 0; k < 4; k++) begin
        plen += $urandom_range(0, 2);
        pat[plen] = 1'b1;
        plen++;
      end
      do_req($urandom_range(0, 1) == 1, 1, $urandom, rand_line(), pat, plen);
    end

    check("exp_q_empty", exp_q.size(), 0);
    check("beat_q_empty", beat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
